// File: rtl/bus_fill.sv
// bus_fill: arbitrates dmem/imem line fills and reads each line as 64-bit beats.
// Define BUS_FILL_RR_ARB_EN for round-robin arbitration (default: dmem priority).
module bus_fill #(
    parameter int LINE    = 256,
    parameter int BLK_LEN = 59
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLK_LEN-1:0] b_addr_d,
    input  logic               b_rd_d,
    output logic [LINE-1:0]    b_data_in_d,
    output logic               b_dv_d,
    input  logic [BLK_LEN-1:0] b_addr_i,
    input  logic               b_rd_i,
    output logic [LINE-1:0]    b_data_in_i,
    output logic               b_dv_i,
    output logic [63:0]        m_addr,
    output logic               m_rd,
    input  logic [63:0]        m_data,
    input  logic               m_dv
);

    localparam int NB = LINE / 64;
    localparam int KW = 64 - 3 - BLK_LEN;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        RECOVER
    } state_t;

    state_t             state;
    logic               gnt_i;
    logic [BLK_LEN-1:0] blk;
    logic [KW-1:0]      k;
    logic [KW-1:0]      k_inc;
    logic [LINE-1:0]    line_buf;
    logic [LINE-1:0]    line_next;
    logic               any_req;
    logic               pick_i;
    logic [BLK_LEN-1:0] pick_addr;

    assign any_req   = b_rd_d | b_rd_i;
    assign k_inc     = k + 1'b1;
    assign pick_addr = pick_i ? b_addr_i : b_addr_d;

`ifdef BUS_FILL_RR_ARB_EN
    // 1 when imem is favoured on the next contested grant
    logic rr_ptr;

    // winner: imem if alone, or if contested and it is imem's turn
    always_comb begin
        pick_i = b_rd_i & (~b_rd_d | rr_ptr);
    end

    // flip the favour away from whoever was just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && any_req) begin
            rr_ptr <= ~pick_i;
        end
    end
`else
    // winner: dmem always beats imem
    always_comb begin
        pick_i = b_rd_i & ~b_rd_d;
    end
`endif

    // assembled line with the arriving beat merged into slot k
    always_comb begin
        line_next = line_buf;
        for (int b = 0; b < NB; b++) begin
            if (k == KW'(b)) begin
                line_next[64*b +: 64] = m_data;
            end
        end
    end

    // fill sequencer; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_i       <= 1'b0;
            blk         <= '0;
            k           <= '0;
            line_buf    <= '0;
            b_data_in_d <= '0;
            b_data_in_i <= '0;
            b_dv_d      <= 1'b0;
            b_dv_i      <= 1'b0;
            m_rd        <= 1'b0;
            m_addr      <= '0;
        end else begin
            b_dv_d <= 1'b0;
            b_dv_i <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_i  <= pick_i;
                        blk    <= pick_addr;
                        k      <= '0;
                        m_rd   <= 1'b1;
                        m_addr <= {pick_addr, {KW{1'b0}}, 3'b000};
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_rd  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (m_dv) begin
                        line_buf <= line_next;
                        if (k == KW'(NB - 1)) begin
                            m_addr <= '0;
                            state  <= DONE;
                            if (gnt_i) begin
                                b_data_in_i <= line_next;
                                b_dv_i      <= 1'b1;
                            end else begin
                                b_data_in_d <= line_next;
                                b_dv_d      <= 1'b1;
                            end
                        end else begin
                            k      <= k_inc;
                            m_addr <= {blk, k_inc, 3'b000};
                            m_rd   <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= RECOVER;
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fill.sv
// tb_bus_fill: directed fills against a transaction-level model of bus_fill.
// Build with BUS_FILL_RR_ARB_EN to expect round-robin grants.
module tb_bus_fill;

    localparam int LINE    = 256;
    localparam int BLK_LEN = 59;
    localparam int NB      = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [BLK_LEN-1:0] b_addr_d = '0;
    logic               b_rd_d = 1'b0;
    logic [LINE-1:0]    b_data_in_d;
    logic               b_dv_d;
    logic [BLK_LEN-1:0] b_addr_i = '0;
    logic               b_rd_i = 1'b0;
    logic [LINE-1:0]    b_data_in_i;
    logic               b_dv_i;
    logic [63:0]        m_addr;
    logic               m_rd;
    logic [63:0]        m_data = '0;
    logic               m_dv = 1'b0;

    bus_fill #(.LINE(LINE), .BLK_LEN(BLK_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .b_addr_d(b_addr_d), .b_rd_d(b_rd_d),
        .b_data_in_d(b_data_in_d), .b_dv_d(b_dv_d),
        .b_addr_i(b_addr_i), .b_rd_i(b_rd_i),
        .b_data_in_i(b_data_in_i), .b_dv_i(b_dv_i),
        .m_addr(m_addr), .m_rd(m_rd),
        .m_data(m_data), .m_dv(m_dv)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_l(input string nm, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // memory: answers each m_rd after mem_delay cycles with seed + beat index
    logic [63:0] mem_seed = 64'hA0;
    int          mem_delay = 1;
    int          pend = 0;
    logic [63:0] pend_data = '0;
    logic        stray_req = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_dv = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        m_dv   = 1'b1;
                        m_data = pend_data;
                    end
                end
                if (m_rd) begin
                    pend      = mem_delay;
                    pend_data = mem_seed + {62'd0, m_addr[4:3]};
                end
                if (stray_req) begin
                    m_dv      = 1'b1;
                    m_data    = 64'hDEAD_BEEF_0BAD_F00D;
                    stray_req = 1'b0;
                end
            end
        end
    end

    // model: fills seen as transactions (grant, beats, delivered line)
    logic               pr_d = 1'b0;
    logic               pr_i = 1'b0;
    logic [BLK_LEN-1:0] pa_d = '0;
    logic [BLK_LEN-1:0] pa_i = '0;
    logic               prev_m_rd = 1'b0;
    logic               in_fill = 1'b0;
    logic               waiting = 1'b0;
    int                 issued = 0;
    int                 got = 0;
    logic               f_gnt_i = 1'b0;
    logic [BLK_LEN-1:0] f_blk = '0;
    logic [LINE-1:0]    f_line = '0;
    logic [63:0]        cur_addr = '0;
    logic [LINE-1:0]    held_d = '0;
    logic [LINE-1:0]    held_i = '0;
    int                 since_dv = 100;
    int                 rd_total = 0;
    logic [63:0]        addr_log [16];
    int                 alog_n = 0;
    logic               gnt_log [8];
    int                 gnt_n = 0;
`ifdef BUS_FILL_RR_ARB_EN
    logic               favour_i = 1'b0;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_b("rst_m_rd", m_rd, 1'b0);
            chk64("rst_m_addr", m_addr, 64'h0);
            chk_b("rst_dv_d", b_dv_d, 1'b0);
            chk_b("rst_dv_i", b_dv_i, 1'b0);
            chk_l("rst_data_d", b_data_in_d, '0);
            chk_l("rst_data_i", b_data_in_i, '0);
            in_fill  = 1'b0;
            waiting  = 1'b0;
            held_d   = '0;
            held_i   = '0;
            since_dv = 100;
`ifdef BUS_FILL_RR_ARB_EN
            favour_i = 1'b0;
`endif
        end else begin
            if (since_dv < 100) since_dv++;
            if (!in_fill && since_dv >= 2 && !m_rd)
                chk64("idle_m_addr", m_addr, 64'h0);
            if (m_rd) begin
                rd_total++;
                chk_b("m_rd_pulse", prev_m_rd, 1'b0);
                if (!in_fill) begin
                    chk_b("grant_has_req", pr_d | pr_i, 1'b1);
                    chk_b("fill_gap", since_dv >= 3, 1'b1);
`ifdef BUS_FILL_RR_ARB_EN
                    f_gnt_i  = pr_i && (!pr_d || favour_i);
                    favour_i = !f_gnt_i;
`else
                    f_gnt_i  = pr_i && !pr_d;
`endif
                    f_blk   = f_gnt_i ? pa_i : pa_d;
                    in_fill = 1'b1;
                    issued  = 0;
                    got     = 0;
                    f_line  = '0;
                end
                chk_b("m_rd_overlap", waiting, 1'b0);
                cur_addr = {f_blk, issued[1:0], 3'b000};
                chk64("m_addr_issue", m_addr, cur_addr);
                addr_log[alog_n % 16] = m_addr;
                alog_n++;
                issued++;
                waiting = 1'b1;
            end else if (in_fill && !(b_dv_d || b_dv_i)) begin
                chk64("m_addr_hold", m_addr, cur_addr);
            end
            if (m_dv && waiting && got < NB) begin
                f_line[got*64 +: 64] = m_data;
                got++;
                waiting = 1'b0;
            end
            chk_b("dv_exclusive", b_dv_d & b_dv_i, 1'b0);
            if (b_dv_d || b_dv_i) begin
                chk_b("dv_in_fill", in_fill, 1'b1);
                chk_i("dv_beats", got, NB);
                chk_b("dv_target", b_dv_i, f_gnt_i);
                if (f_gnt_i) held_i = f_line;
                else held_d = f_line;
                gnt_log[gnt_n % 8] = b_dv_i;
                gnt_n++;
                in_fill  = 1'b0;
                since_dv = 0;
            end
            chk_l("data_d", b_data_in_d, held_d);
            chk_l("data_i", b_data_in_i, held_i);
        end
        pr_d      = b_rd_d;
        pr_i      = b_rd_i;
        pa_d      = b_addr_d;
        pa_i      = b_addr_i;
        prev_m_rd = m_rd;
    end

    // one requester fill: raise rd in an IDLE cycle, wait for dv, drop rd
    task automatic do_fill(input logic sel_i, input logic [BLK_LEN-1:0] blk,
                           output int lat);
        int   c0;
        logic seen;
        seen = 1'b0;
        lat  = -1;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (sel_i) begin
            b_addr_i = blk;
            b_rd_i   = 1'b1;
        end else begin
            b_addr_d = blk;
            b_rd_d   = 1'b1;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((sel_i ? b_dv_i : b_dv_d) === 1'b1) begin
                lat  = cyc - c0;
                seen = 1'b1;
                break;
            end
        end
        chk_b("fill_done", seen, 1'b1);
        @(posedge clk);
        #1;
        if (sel_i) b_rd_i = 1'b0;
        else b_rd_d = 1'b0;
    endtask

    logic [LINE-1:0] line_a;
    logic [LINE-1:0] line_1k;
    int lat;
    int a0;
    int r0;
    int g0;

    initial begin
        line_a  = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        line_1k = {64'h1003, 64'h1002, 64'h1001, 64'h1000};

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // dmem fill of block 1
        mem_seed  = 64'hA0;
        mem_delay = 1;
        a0 = alog_n;
        do_fill(1'b0, 59'h1, lat);
        chk_i("lat_d", lat, 9);
        chk64("addr_b0", addr_log[a0 % 16], 64'h20);
        chk64("addr_b1", addr_log[(a0 + 1) % 16], 64'h28);
        chk64("addr_b2", addr_log[(a0 + 2) % 16], 64'h30);
        chk64("addr_b3", addr_log[(a0 + 3) % 16], 64'h38);
        chk_l("line_d_first", b_data_in_d, line_a);
        chk_l("line_i_zero", b_data_in_i, '0);

        // stray beat in IDLE, then slow imem fill
        @(posedge clk);
        #1;
        stray_req = 1'b1;
        repeat (3) @(posedge clk);
        mem_seed  = 64'h1000;
        mem_delay = 3;
        r0 = rd_total;
        do_fill(1'b1, 59'h123, lat);
        chk_i("lat_i_slow", lat, 17);
        chk_i("m_rd_count", rd_total - r0, 4);
        chk_l("line_i", b_data_in_i, line_1k);
        chk_l("line_d_kept", b_data_in_d, line_a);

        // dmem address changes after grant
        mem_seed  = 64'h2000;
        mem_delay = 1;
        a0 = alog_n;
        fork
            do_fill(1'b0, 59'h7, lat);
            begin
                repeat (3) @(posedge clk);
                #2;
                b_addr_d = 59'h55;
            end
        join
        chk_i("lat_d2", lat, 9);
        chk64("latched_b2", addr_log[(a0 + 2) % 16], 64'hF0);
        chk64("latched_b3", addr_log[(a0 + 3) % 16], 64'hF8);
        chk_l("line_d2", b_data_in_d,
              {64'h2003, 64'h2002, 64'h2001, 64'h2000});
        chk_l("line_i_held", b_data_in_i, line_1k);

        // reset in WAIT of beat 2
        mem_seed  = 64'h3000;
        mem_delay = 3;
        @(posedge clk);
        #1;
        b_addr_d = 59'h4;
        b_rd_d   = 1'b1;
        for (int n = 0; n < 100 && !(issued == 3 && waiting); n++)
            @(negedge clk);
        chk_i("reached_beat2", issued, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("async_m_rd", m_rd, 1'b0);
        chk64("async_m_addr", m_addr, 64'h0);
        chk_b("async_dv_d", b_dv_d, 1'b0);
        chk_l("async_data_d", b_data_in_d, '0);
        chk_l("async_data_i", b_data_in_i, '0);
        b_rd_d = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mem_seed  = 64'h4000;
        mem_delay = 1;
        do_fill(1'b0, 59'h9, lat);
        chk_i("lat_after_rst", lat, 9);
        chk_l("line_after_rst", b_data_in_d,
              {64'h4003, 64'h4002, 64'h4001, 64'h4000});
        chk_l("line_i_cleared", b_data_in_i, '0);

        // both requesters held high from reset release
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        b_addr_d = 59'hD0;
        b_addr_i = 59'hE0;
        b_rd_d   = 1'b1;
        b_rd_i   = 1'b1;
        mem_seed = 64'h5000;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        g0 = gnt_n;
        for (int n = 0; n < 400 && (gnt_n - g0) < 4; n++)
            @(negedge clk);
        chk_i("arb_fills", gnt_n - g0, 4);
        @(posedge clk);
        #1;
        b_rd_d = 1'b0;
        b_rd_i = 1'b0;
`ifdef BUS_FILL_RR_ARB_EN
        chk_b("arb_g0", gnt_log[g0 % 8], 1'b0);
        chk_b("arb_g1", gnt_log[(g0 + 1) % 8], 1'b1);
        chk_b("arb_g2", gnt_log[(g0 + 2) % 8], 1'b0);
        chk_b("arb_g3", gnt_log[(g0 + 3) % 8], 1'b1);
`else
        chk_b("arb_g0", gnt_log[g0 % 8], 1'b0);
        chk_b("arb_g1", gnt_log[(g0 + 1) % 8], 1'b0);
        chk_b("arb_g2", gnt_log[(g0 + 2) % 8], 1'b0);
        chk_b("arb_g3", gnt_log[(g0 + 3) % 8], 1'b0);
`endif
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/bus_fill.md
# bus_fill

Line-fill controller downstream of `dmem` and `imem`. It accepts block-fill requests from both caches and arbitrates between them. For the granted cache it reads one cache line from external memory as consecutive 64-bit beats, assembles the line, and returns it with a one-cycle data-valid pulse. One fill is in flight at a time, with one outstanding memory beat.

## Interface
- `LINE`, default 256 — cache line width in bits; a multiple of 64; equals `DMEM_LINE`.
- `BLK_LEN`, default 59 — block address width; equals `DMEM_BLK_LEN`, i.e. 64 − log2(LINE/8).
- `clk`, in, 1 — single clock; all state updates on the rising edge.
- `rst_n`, in, 1 — asynchronous, active-low reset.
- `b_addr_d`, in, BLK_LEN — dmem block address.
- `b_rd_d`, in, 1 — dmem fill request; level, held until `b_dv_d`.
- `b_data_in_d`, out, LINE — line delivered to dmem.
- `b_dv_d`, out, 1 — one-cycle pulse: `b_data_in_d` valid.
- `b_addr_i`, in, BLK_LEN — imem block address.
- `b_rd_i`, in, 1 — imem fill request.
- `b_data_in_i`, out, LINE — line delivered to imem.
- `b_dv_i`, out, 1 — imem valid pulse.
- `m_addr`, out, 64 — external memory byte address of the current beat.
- `m_rd`, out, 1 — one-cycle beat read request.
- `m_data`, in, 64 — beat data.
- `m_dv`, in, 1 — beat valid; earliest one cycle after `m_rd`.

## Operation
- NB = LINE/64 beats per line. Beat k fills line bits [64k+63:64k].
- Address of beat k is {blk, k, 3'b000}. The k field is log2(NB) bits wide.
- FSM states:
  - IDLE: if any request is high, latch the winner (grant id, block address), clear the beat counter, go to ISSUE.
  - ISSUE: `m_rd`=1 for exactly one cycle; go to WAIT.
  - WAIT: on `m_dv`, store `m_data` into beat k.
    - If k=NB−1, go to DONE.
    - Otherwise increment k and go to ISSUE.
  - DONE: copy the assembled line to the granted requester's `b_data_in_x` and pulse its `b_dv_x`; go to RECOVER.
  - RECOVER: one idle cycle so the requester can drop `b_rd_x`; go to IDLE.
- Arbitration happens only in IDLE. The address is latched at grant, so later changes to `b_addr_x` are ignored until the next grant.
- The line is assembled in an internal buffer. `b_data_in_x` changes only in DONE and holds its value until that requester's next DONE.
- `m_dv` is ignored outside WAIT. No error path: the memory always responds.
- Reset outputs: `b_data_in_d`=0, `b_data_in_i`=0, `b_dv_d`=0, `b_dv_i`=0, `m_rd`=0, `m_addr`=0. FSM goes to IDLE and the RR pointer to dmem.
- Reset asserted mid-fill aborts the fill: no `dv` pulse, buffer cleared, state IDLE.

## Timing
- Request sampled in IDLE at cycle 0.
  - ISSUE for beat k occurs at cycle 1+2k, given `m_dv` one cycle after each `m_rd`.
  - DONE (`dv`=1) at cycle 2·NB+1, i.e. cycle 9 for NB=4.
  - Every memory wait cycle adds one cycle.
- `m_addr` is stable from ISSUE through the end of WAIT for the same beat. It is 0 in IDLE.
- Back-to-back fills: minimum gap from one DONE to the next ISSUE is 3 cycles (DONE, RECOVER, IDLE).
- `b_dv_d` and `b_dv_i` are never high in the same cycle.

## Configuration
- `BUS_FILL_RR_ARB_EN` defined: round-robin arbitration.
  - When both requests are high in IDLE, grant the requester not granted most recently.
  - The pointer updates at each grant and resets to favour dmem.
- Undefined: fixed priority, dmem always wins over imem. No pointer register.

## Test plan
- dmem fill, `b_addr_d`=59'h1, memory returns 64'hA0..A3 one cycle after each `m_rd`:
  - `m_addr` sequence is 0x20, 0x28, 0x30, 0x38.
  - `b_dv_d` pulses at cycle 9.
  - `b_data_in_d` = {A3,A2,A1,A0}.
  - `b_data_in_i` stays 0.
- imem fill with a 3-cycle memory delay per beat: `b_dv_i` at cycle 17; `m_rd` is exactly one cycle per beat; a stray `m_dv` injected in IDLE does not alter the line.
- Both requests high at reset release:
  - With `BUS_FILL_RR_ARB_EN`: grants go d, i, d, i across four consecutive fills.
  - Without it: grants go d, d, d while `b_rd_d` stays high and `b_rd_i` starves.
- Changing `b_addr_d` during WAIT: `m_addr` still follows the latched block for all remaining beats.
- `rst_n` pulled low during WAIT of beat 2:
  - All outputs go to 0 asynchronously and no `dv` pulse occurs.
  - After release, a new request completes normally with fresh data.
- After a completed imem fill, a dmem fill leaves `b_data_in_i` unchanged and updates `b_data_in_d` only at its own DONE.
